// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// instr_sequencer : program RAM that issues 13-bit instructions in order,
//                   with idle gaps inserted after each multiply.
// Revision 1.0
// ============================================================================
module instr_sequencer #(
    parameter int          AW         = 4,
    parameter int          MUL_WAIT   = 2,
    parameter logic [12:0] IDLE_INSTR = 13'b1011111111111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [12:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          proc_ready,
    output logic [12:0]   instruction,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    localparam int              c_DEPTH     = 2 ** AW;
    localparam int              c_CW        = (MUL_WAIT < 2) ? 1 : $clog2(MUL_WAIT + 1);
    localparam logic [AW:0]     c_MAX_LEN   = (AW + 1)'(c_DEPTH);
    localparam logic [c_CW-1:0] c_WAIT_LOAD = c_CW'(MUL_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic [AW-1:0]   r_pc, w_pc_nx;
    logic [AW:0]     r_len, w_len_nx;
    logic [c_CW-1:0] r_cnt, w_cnt_nx;
    logic            w_zero_start;
    logic            w_last;
    logic            w_is_mul;

    logic [12:0]     r_ram [c_DEPTH];
    logic [12:0]     r_instr;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    // r_instr always holds ram[pc] while issuing, so decode the op from it
    assign w_last   = ({1'b0, r_pc} == (r_len - 1'b1));
    assign w_is_mul = (r_instr[12:11] == 2'b11);

    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_len_nx     = r_len;
        w_cnt_nx     = r_cnt;
        w_zero_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (prog_len == '0) begin
                        w_zero_start = 1'b1;
                    end else begin
                        w_len_nx   = (prog_len > c_MAX_LEN) ? c_MAX_LEN : prog_len;
                        w_pc_nx    = '0;
                        w_state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (proc_ready) begin
                    if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_pc_nx = r_pc + 1'b1;
                        if (w_is_mul && (MUL_WAIT > 0)) begin
                            w_cnt_nx   = c_WAIT_LOAD;
                            w_state_nx = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= c_CW'(1)) begin
                    w_state_nx = S_ISSUE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Program RAM: no reset, so a loaded program survives rst
    always_ff @(posedge clk) begin
        if (prog_we && !r_busy) begin
            r_ram[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_instr <= IDLE_INSTR;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_len   <= w_len_nx;
            r_cnt   <= w_cnt_nx;
            r_instr <= (w_state_nx == S_ISSUE) ? r_ram[w_pc_nx] : IDLE_INSTR;
            r_valid <= (w_state_nx == S_ISSUE);
            r_busy  <= (w_state_nx == S_ISSUE) || (w_state_nx == S_WAIT);
            r_done  <= (w_state_nx == S_DONE) || w_zero_start;
        end
    end

    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pc          = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_instr_sequencer : directed self-checking bench for instr_sequencer
// Revision 1.0
// ============================================================================
module tb_instr_sequencer;

    localparam int          AW         = 4;
    localparam int          MUL_WAIT   = 2;
    localparam logic [12:0] IDLE_INSTR = 13'b1011111111111;

    logic          clk;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [12:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          proc_ready;
    logic [12:0]   instruction;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] prog [16];

    instr_sequencer #(
        .AW         (AW),
        .MUL_WAIT   (MUL_WAIT),
        .IDLE_INSTR (IDLE_INSTR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .proc_ready  (proc_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Samples the current cycle, then advances; bounded by max
    task automatic run_count(input int max, output int nvalid, output int ndone);
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) nvalid++;
            if (done) ndone++;
            tick();
        end
    endtask

    task automatic do_start(input logic [AW:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int nv;
        int nd;
        logic [12:0] e_instr;
        logic        e_valid;
        logic        e_busy;
        logic [3:0]  e_pc;

        prog[0] = 13'h0800;  // ld A1 @0
        prog[1] = 13'h0A00;  // ld A2 @0
        prog[2] = 13'h17FF;  // add A4 @511 (same bits as the idle word)
        prog[3] = 13'h0440;  // st A3 @64
        prog[4] = 13'h0840;  // ld A1 @64
        prog[5] = 13'h1800;  // mul
        prog[6] = 13'h0440;  // st A3 @64
        prog[7] = 13'h0E40;  // ld A4 @64
        for (int k = 8; k < 16; k++) prog[k] = 13'h0800 + 13'(k);

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; proc_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_busy",  32'(busy),        32'd0);
        chk("reset_done",  32'(done),        32'd0);
        chk("reset_pc",    32'(pc),          32'd0);
        chk("reset_instr", 32'(instruction), 32'(IDLE_INSTR));

        for (int k = 0; k < 16; k++) begin
            prog_we = 1'b1; prog_addr = 4'(k); prog_data = prog[k];
            tick();
        end
        prog_we = 1'b0;

        // Basic 8-word run: words on cycles 1-6 and 9-10, done on 11
        do_start(5'd8);
        for (int c = 1; c <= 11; c++) begin
            if (c <= 6)       begin e_valid = 1; e_instr = prog[c-1]; e_pc = 4'(c-1); e_busy = 1; end
            else if (c <= 8)  begin e_valid = 0; e_instr = IDLE_INSTR; e_pc = 4'd6; e_busy = 1; end
            else if (c <= 10) begin e_valid = 1; e_instr = prog[c-3]; e_pc = 4'(c-3); e_busy = 1; end
            else              begin e_valid = 0; e_instr = IDLE_INSTR; e_pc = 4'd7; e_busy = 0; end
            chk($sformatf("run_c%0d_valid", c), 32'(instr_valid), 32'(e_valid));
            chk($sformatf("run_c%0d_instr", c), 32'(instruction), 32'(e_instr));
            chk($sformatf("run_c%0d_pc", c),    32'(pc),          32'(e_pc));
            chk($sformatf("run_c%0d_busy", c),  32'(busy),        32'(e_busy));
            chk($sformatf("run_c%0d_done", c),  32'(done),        32'(c == 11));
            tick();
        end
        chk("run_done_clears", 32'(done), 32'd0);
        tick();

        // Stall on word 2 for three cycles
        do_start(5'd8);
        tick();
        tick();
        proc_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d_instr", s), 32'(instruction), 32'h17FF);
            chk($sformatf("stall%0d_pc", s),    32'(pc),          32'd2);
            chk($sformatf("stall%0d_valid", s), 32'(instr_valid), 32'd1);
            tick();
        end
        proc_ready = 1'b1;
        chk("stall_release_instr", 32'(instruction), 32'h17FF);
        tick();
        chk("stall_advance_instr", 32'(instruction), 32'(prog[3]));
        chk("stall_advance_pc",    32'(pc),          32'd3);
        run_count(30, nv, nd);
        chk("stall_rest_valid", 32'(nv), 32'd5);
        chk("stall_rest_done",  32'(nd), 32'd1);

        // Zero-length start
        do_start(5'd0);
        chk("zero_done",  32'(done),        32'd1);
        chk("zero_busy",  32'(busy),        32'd0);
        chk("zero_valid", 32'(instr_valid), 32'd0);
        run_count(10, nv, nd);
        chk("zero_after_valid", 32'(nv), 32'd0);
        chk("zero_after_done",  32'(nd), 32'd1);

        // Writes and restart ignored while busy
        do_start(5'd8);
        tick();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 13'h1FFF;
        prog_len = 5'd3; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        run_count(30, nv, nd);
        chk("busy_ign_valid", 32'(nv), 32'd6);
        chk("busy_ign_done",  32'(nd), 32'd1);
        do_start(5'd8);
        chk("busy_ign_ram0", 32'(instruction), 32'(prog[0]));
        run_count(30, nv, nd);

        // Reset mid-run at word 4, then replay
        do_start(5'd8);
        for (int s = 0; s < 4; s++) tick();
        chk("rst_at_word4", 32'(instruction), 32'(prog[4]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'(IDLE_INSTR));
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        do_start(5'd8);
        chk("replay_instr", 32'(instruction), 32'(prog[0]));
        chk("replay_valid", 32'(instr_valid), 32'd1);
        run_count(30, nv, nd);
        chk("replay_valid_cnt", 32'(nv), 32'd8);
        chk("replay_done",      32'(nd), 32'd1);

        // Mul as last word: no wait cycles before done
        do_start(5'd6);
        for (int s = 0; s < 5; s++) tick();
        chk("mullast_word", 32'(instruction), 32'(prog[5]));
        tick();
        chk("mullast_done",  32'(done),        32'd1);
        chk("mullast_valid", 32'(instr_valid), 32'd0);
        run_count(5, nv, nd);

        // Oversized length clamps to 16
        do_start(5'd17);
        run_count(40, nv, nd);
        chk("clamp_valid_cnt", 32'(nv), 32'd16);
        chk("clamp_done",      32'(nd), 32'd1);
        chk("clamp_pc",        32'(pc), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
